// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: resolves a decoded RISC-V conditional branch and hands the next PC to fetch
module branch_redirect_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [XLEN-1:0] req_pc_i,
  input  logic [XLEN-1:0] req_imm_i,
  input  logic            kill_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            out_taken_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic            out_misalign_o,
  output logic            out_illegal_o
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_e;
  state_e state_q, state_d;
  logic [2:0] f3_q;
  logic [XLEN-1:0] a_q, b_q, pc_q, imm_q, npc_q, npc_d;
  logic valid_q, taken_q, mis_q, ill_q;
  logic [XLEN:0] diff;
  logic eq, lt, ltu, cond, ill, taken_d, accept;
  // one subtractor yields equality, signed and unsigned ordering
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign eq  = diff[XLEN-1:0] == '0;
  assign ltu = diff[XLEN];
  assign lt  = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? a_q[XLEN-1] : diff[XLEN-1];
  assign ill = f3_q[2:1] == 2'b01;
  assign cond = f3_q[2] ? (f3_q[1] ? ltu : lt) ^ f3_q[0] : eq ^ f3_q[0];
  assign taken_d = cond && !ill;
  assign npc_d = taken_d ? pc_q + imm_q : pc_q + XLEN'(4);
  assign accept = state_q == IDLE && req_valid_i && !kill_i;
  always_comb begin
    state_d = state_q;
    if (kill_i) state_d = IDLE;
    else case (state_q)
      IDLE:    state_d = req_valid_i ? EVAL : IDLE;
      EVAL:    state_d = HOLD;
      HOLD:    state_d = out_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      npc_q   <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q  <= req_funct3_i;
        a_q   <= req_rs1_i;
        b_q   <= req_rs2_i;
        pc_q  <= req_pc_i;
        imm_q <= req_imm_i;
      end
      if (state_q == EVAL && !kill_i) begin
        valid_q <= 1'b1;
        taken_q <= taken_d;
        npc_q   <= npc_d;
        mis_q   <= taken_d && npc_d[1:0] != 2'b00;
        ill_q   <= ill;
      end else if (kill_i || (state_q == HOLD && out_ready_i)) begin
        valid_q <= 1'b0;
      end
    end
  end
  assign req_ready_o    = state_q == IDLE;
  assign out_valid_o    = valid_q;
  assign out_taken_o    = taken_q;
  assign out_pc_o       = npc_q;
  assign out_misalign_o = mis_q;
  assign out_illegal_o  = ill_q;
endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb_branch_redirect_unit: directed and randomized checks of branch_redirect_unit against a transaction-level model
module tb_branch_redirect_unit;
  logic clk = 0, rst = 1;
  logic req_valid = 0, kill = 0, out_ready = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_rs1 = 0, req_rs2 = 0, req_pc = 0, req_imm = 0;
  logic req_ready, out_valid, out_taken, out_misalign, out_illegal;
  logic [31:0] out_pc;
  int tests = 0, fails = 0;

  branch_redirect_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_pc_i(req_pc), .req_imm_i(req_imm),
    .kill_i(kill), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_taken_o(out_taken), .out_pc_o(out_pc),
    .out_misalign_o(out_misalign), .out_illegal_o(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic cond_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // model: where the branch is in its life (0 waiting, 1 evaluating, 2 offered) and what it must report
  int ph = 0;
  logic [2:0] m_f3;
  logic [31:0] m_a, m_b, m_pcin, m_imm, m_pc;
  logic m_valid, m_taken, m_mis, m_ill;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_valid = 0; m_taken = 0; m_pc = 0; m_mis = 0; m_ill = 0;
    end else if (kill) begin
      ph = 0; m_valid = 0;
    end else if (ph == 0) begin
      if (req_valid) begin
        m_f3 = req_funct3; m_a = req_rs1; m_b = req_rs2; m_pcin = req_pc; m_imm = req_imm; ph = 1;
      end
    end else if (ph == 1) begin
      m_ill = m_f3 == 3'b010 || m_f3 == 3'b011;
      m_taken = cond_of(m_f3, m_a, m_b);
      m_pc = m_taken ? m_pcin + m_imm : m_pcin + 32'd4;
      m_mis = m_taken && (m_pc % 4) != 0;
      m_valid = 1; ph = 2;
    end else if (out_ready) begin
      m_valid = 0; ph = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("handshake", {62'd0, req_ready, out_valid}, {62'd0, ph == 0, m_valid});
      if (m_valid)
        chk("result", {29'd0, out_taken, out_misalign, out_illegal, out_pc}, {29'd0, m_taken, m_mis, m_ill, m_pc});
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, " idle"}, {63'd0, req_ready}, 64'd1);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, b, pc, imm);
    req_valid = 1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_pc = pc; req_imm = imm;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic run_branch(input string nm, input logic [2:0] f3, input logic [31:0] a, b, pc, imm,
                            input int hold, input logic et, input logic [31:0] epc, input logic em, ei);
    wait_idle(nm);
    issue(f3, a, b, pc, imm);
    chk({nm, " lat1"}, {62'd0, out_valid, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk({nm, " lat2"}, {63'd0, out_valid}, 64'd1);
    chk({nm, " res"}, {29'd0, out_taken, out_misalign, out_illegal, out_pc}, {29'd0, et, em, ei, epc});
    repeat (hold) begin
      @(posedge clk); #1;
      chk({nm, " hold"}, {27'd0, out_valid, req_ready, out_taken, out_misalign, out_illegal, out_pc},
          {27'd0, 2'b10, et, em, ei, epc});
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({nm, " done"}, {62'd0, out_valid, req_ready}, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2;
    chk("reset", {27'd0, req_ready, out_valid, out_taken, out_misalign, out_illegal, out_pc}, {27'd0, 5'b10000, 32'd0});
    #10 rst = 0;
    @(posedge clk); #1;
    run_branch("beq", 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 5, 1, 32'h120, 0, 0);
    run_branch("blt", 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 0, 1, 32'h210, 0, 0);
    run_branch("bltu", 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 0, 0, 32'h204, 0, 0);
    run_branch("bge", 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'h40, 1, 0, 32'h304, 0, 0);
    run_branch("bgeu", 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'h40, 0, 1, 32'h340, 0, 0);
    run_branch("bne wrap", 3'b001, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h8, 0, 1, 32'h4, 0, 0);
    run_branch("bne mis", 3'b001, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h6, 0, 1, 32'h2, 1, 0);
    run_branch("illegal", 3'b010, 32'd1, 32'd1, 32'hFFFFFFFC, 32'h8, 2, 0, 32'h0, 0, 1);
    run_branch("beq nt", 3'b000, 32'd1, 32'd2, 32'h1000, 32'hFFFFFFF0, 0, 0, 32'h1004, 0, 0);
    wait_idle("kill eval");
    issue(3'b000, 32'd7, 32'd7, 32'h40, 32'h8);
    kill = 1;
    @(posedge clk); #1;
    kill = 0;
    chk("kill eval", {62'd0, out_valid, req_ready}, 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("kill quiet", {63'd0, out_valid}, 64'd0);
    end
    kill = 1; req_valid = 1;
    @(posedge clk); #1;
    kill = 0; req_valid = 0;
    chk("kill idle", {62'd0, out_valid, req_ready}, 64'd1);
    issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    @(posedge clk); #1;
    chk("rst hold pre", {63'd0, out_valid}, 64'd1);
    rst = 1;
    #1;
    chk("rst hold", {29'd0, out_valid, req_ready, out_taken, out_pc}, {29'd0, 3'b010, 32'd0});
    #2 rst = 0;
    @(posedge clk); #1;
    run_branch("post rst", 3'b111, 32'd3, 32'd3, 32'h500, 32'h4, 0, 1, 32'h504, 0, 0);
    repeat (600) begin
      @(posedge clk); #1;
      req_valid = $urandom_range(0, 2) == 0;
      req_funct3 = 3'($urandom);
      req_rs1 = pick();
      req_rs2 = $urandom_range(0, 3) == 0 ? req_rs1 : pick();
      req_pc = $urandom_range(0, 1) ? pick() : $urandom;
      req_imm = $urandom_range(0, 1) ? (32'($urandom_range(0, 63)) << 1) : ($urandom & 32'hFFFFFFFE);
      out_ready = $urandom_range(0, 1);
      kill = $urandom_range(0, 15) == 0;
    end
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
